// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staggered reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  // One counter serves both the stretch and the inter-channel gap.
  function automatic int cnt_width(input int min_pulse, input int stagger);
    int longest;
    longest = (min_pulse > stagger) ? min_pulse : stagger;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-bit flop chain that brings asynchronous request lines into the clock domain.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Merges power-on reset with synchronised requests, stretches the reset and
// releases the active-low channels one by one in index order.
//
//   state   | meaning
//   HOLD    | power-on reset asserted; stretch counter preloaded
//   STRETCH | all channels held in reset until the counter expires
//   RELEASE | channels deasserting, one every STAGGER cycles
//   RUN     | all channels released, DONE high
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int N_REQ       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4,
  parameter int STAGGER     = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] REQ_IN,
  input  logic             CAUSE_CLR,
  output logic [N_CH-1:0]  RESET_OUT,
  output logic             DONE,
  output logic [N_REQ-1:0] CAUSE
);

  localparam int CW = cnt_width(MIN_PULSE, STAGGER);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] PULSE_RELOAD = CW'(MIN_PULSE - 1);
  localparam logic [CW-1:0] GAP_RELOAD   = CW'(STAGGER - 1);
  localparam logic [IW-1:0] LAST_CH      = IW'(N_CH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [IW-1:0]    ch, ch_nx;
  logic [N_CH-1:0]  rst_out_nx;
  logic             done_nx;
  logic [N_REQ-1:0] cause_nx;
  logic [N_REQ-1:0] req_s;
  logic             req_any;

  sync_chain #(
    .WIDTH  (N_REQ),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (CLOCK),
    .rst (RESET),
    .d   (REQ_IN),
    .q   (req_s)
  );

  assign req_any = |req_s;

  // The counter is preloaded during reset so the reset edge itself counts
  // as the first stretch cycle, matching a request-triggered stretch.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= HOLD;
      cnt       <= PULSE_RELOAD;
      ch        <= '0;
      RESET_OUT <= '0;
      DONE      <= 1'b0;
      CAUSE     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ch        <= ch_nx;
      RESET_OUT <= rst_out_nx;
      DONE      <= done_nx;
      CAUSE     <= cause_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ch_nx      = ch;
    rst_out_nx = RESET_OUT;
    done_nx    = DONE;
    cause_nx   = (CAUSE_CLR ? '0 : CAUSE) | req_s;

    if (req_any) begin
      state_nx   = STRETCH;
      cnt_nx     = PULSE_RELOAD;
      ch_nx      = '0;
      rst_out_nx = '0;
      done_nx    = 1'b0;
    end else begin
      case (state)
        HOLD, STRETCH: begin
          if (cnt == '0) begin
            rst_out_nx[0] = 1'b1;
            cnt_nx        = GAP_RELOAD;
            ch_nx         = IW'(1);
            if (N_CH == 1) begin
              state_nx = RUN;
              done_nx  = 1'b1;
            end else begin
              state_nx = RELEASE;
            end
          end else begin
            cnt_nx   = cnt - CW'(1);
            state_nx = STRETCH;
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            for (int i = 0; i < N_CH; i++) begin
              if (IW'(i) == ch) rst_out_nx[i] = 1'b1;
            end
            cnt_nx = GAP_RELOAD;
            if (ch == LAST_CH) begin
              state_nx = RUN;
              done_nx  = 1'b1;
            end else begin
              ch_nx = ch + IW'(1);
            end
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        RUN: begin
          rst_out_nx = '1;
          done_nx    = 1'b1;
        end
        default: state_nx = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: constant vector table plus an edge-timing model
// whose predictions go through a scoreboard queue.
module tb_reset_sequencer;

  localparam int N_CH = 3;
  localparam int MP   = 4;
  localparam int ST   = 2;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] REQ_IN = 2'b00;
  logic       CAUSE_CLR = 1'b0;
  logic [2:0] RESET_OUT;
  logic       DONE;
  logic [1:0] CAUSE;

  reset_sequencer dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .REQ_IN    (REQ_IN),
    .CAUSE_CLR (CAUSE_CLR),
    .RESET_OUT (RESET_OUT),
    .DONE      (DONE),
    .CAUSE     (CAUSE)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [2:0] rst_out;
    logic       done;
    logic [1:0] cause;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic       clr;
    exp_t       exp;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[$];
  int         tests = 0;
  int         fails = 0;
  int         n_edge = 0;
  int         e0 = 0;
  logic [1:0] s0_m = 2'b00;
  logic [1:0] s1_m = 2'b00;
  logic [1:0] cause_m = 2'b00;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing model: everything follows from the distance to the last trigger edge.
  task automatic predict(input logic rst, input logic [1:0] req, input logic clr);
    exp_t       e;
    logic [1:0] rs;
    int         d;
    n_edge++;
    rs = s1_m;
    if (rst) begin
      e0      = n_edge;
      cause_m = 2'b00;
      s0_m    = 2'b00;
      s1_m    = 2'b00;
    end else begin
      if (rs != 2'b00) e0 = n_edge;
      cause_m = (clr ? 2'b00 : cause_m) | rs;
      s1_m    = s0_m;
      s0_m    = req;
    end
    d = n_edge - e0;
    for (int i = 0; i < N_CH; i++) e.rst_out[i] = (d >= MP + i * ST);
    e.done  = (d >= MP + (N_CH - 1) * ST);
    e.cause = cause_m;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [1:0] req, input logic clr);
    exp_t e;
    @(negedge CLOCK);
    RESET     = rst;
    REQ_IN    = req;
    CAUSE_CLR = clr;
    predict(rst, req, clr);
    @(posedge CLOCK);
    #1;
    e = sb_q.pop_front();
    check($sformatf("model_edge%0d", n_edge), 8'({RESET_OUT, DONE, CAUSE}), 8'(e));
  endtask

  task automatic add(input logic rst, input logic [1:0] req, input logic clr,
                     input logic [2:0] ro, input logic dn, input logic [1:0] cs);
    vec_t v;
    v.rst = rst; v.req = req; v.clr = clr;
    v.exp.rst_out = ro; v.exp.done = dn; v.exp.cause = cs;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Power-on: five reset cycles, then e0+1..e0+10 idle.
    for (int i = 0; i < 5; i++) add(1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00);
    add(0, 2'b00, 0, 3'b000, 0, 2'b00);
    add(0, 2'b00, 0, 3'b000, 0, 2'b00);
    add(0, 2'b00, 0, 3'b000, 0, 2'b00);
    add(0, 2'b00, 0, 3'b001, 0, 2'b00);
    add(0, 2'b00, 0, 3'b001, 0, 2'b00);
    add(0, 2'b00, 0, 3'b011, 0, 2'b00);
    add(0, 2'b00, 0, 3'b011, 0, 2'b00);
    add(0, 2'b00, 0, 3'b111, 1, 2'b00);
    add(0, 2'b00, 0, 3'b111, 1, 2'b00);
    add(0, 2'b00, 0, 3'b111, 1, 2'b00);
    // Request in RUN: REQ_IN[1] for three captures starting at edge r.
    add(0, 2'b10, 0, 3'b111, 1, 2'b00);
    add(0, 2'b10, 0, 3'b111, 1, 2'b00);
    add(0, 2'b10, 0, 3'b000, 0, 2'b10);
    for (int i = 3; i <= 7; i++) add(0, 2'b00, 0, 3'b000, 0, 2'b10);
    add(0, 2'b00, 0, 3'b001, 0, 2'b10);
    add(0, 2'b00, 0, 3'b001, 0, 2'b10);
    add(0, 2'b00, 0, 3'b011, 0, 2'b10);
    add(0, 2'b00, 0, 3'b011, 0, 2'b10);
    add(0, 2'b00, 0, 3'b111, 1, 2'b10);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].clr);
      check($sformatf("vec%0d", i), 8'({RESET_OUT, DONE, CAUSE}), 8'(vecs[i].exp));
    end

    // Mid-release abort: second request captured on the edge releasing channel 0.
    step(1'b0, 2'b01, 1'b0);
    idle(5);
    step(1'b0, 2'b01, 1'b0);
    check("mid_release_ch0", 8'(RESET_OUT), 8'(3'b001));
    idle(1);
    check("mid_release_hold", 8'(RESET_OUT), 8'(3'b001));
    idle(1);
    check("abort_reassert", 8'({RESET_OUT, DONE}), 8'(4'b0000));
    idle(12);
    check("after_abort_run", 8'({RESET_OUT, DONE}), 8'(4'b1111));

    // Extended stretch.
    for (int i = 0; i < 20; i++) step(1'b0, 2'b01, 1'b0);
    check("long_req_held", 8'(RESET_OUT), 8'(3'b000));
    idle(12);

    // CAUSE clear, then clear colliding with a set of bit 1.
    check("cause_accum", 8'(CAUSE), 8'(2'b11));
    step(1'b0, 2'b00, 1'b1);
    check("cause_clr", 8'(CAUSE), 8'(2'b00));
    step(1'b0, 2'b10, 1'b0);
    idle(1);
    step(1'b0, 2'b00, 1'b1);
    check("cause_clr_vs_set", 8'(CAUSE), 8'(2'b10));
    idle(12);

    // RESET mid-stretch with a request still active.
    for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    check("reset_clears_cause", 8'({RESET_OUT, DONE, CAUSE}), 8'(6'b000000));
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 2'b00, 1'b0);
      if (k == 3) check("post_reset_e0p3", 8'(RESET_OUT), 8'(3'b000));
      if (k == 4) check("post_reset_e0p4", 8'(RESET_OUT), 8'(3'b001));
      if (k == 6) check("post_reset_e0p6", 8'(RESET_OUT), 8'(3'b011));
      if (k == 8) check("post_reset_e0p8", 8'({RESET_OUT, DONE}), 8'(4'b1111));
    end

    // Sparse random requests and clears against the timing model.
    for (int i = 0; i < 80; i++) begin
      logic [1:0] rq;
      logic       cl;
      rq = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cl = ($urandom_range(0, 11) == 0);
      step(1'b0, rq, cl);
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
